// File: rtl/matmul_engine.sv
// Purpose: N x N unsigned matrix multiply C = A x B, streamed row-major over valid/ready.
// Latency: first element N+1 cycles after start; with ready held high, one element per N+2 cycles.
// Backpressure: while res_ready is low, res_data and res_last are held and no further memory reads occur.
module matmul_engine #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 4,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        size,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, OUT, FIN} state_t;

  localparam logic [2:0] MAX_N_S = 3'(MAX_N);

  state_t              state_q, state_d;
  logic [2:0]          n_q, i_q, j_q, k_q;
  logic [2:0]          n_m1;
  logic [ACC_W-1:0]    acc_q;
  logic [2*DATA_W-1:0] prod;
  logic                size_ok, last_el, accept;

  assign n_m1    = n_q - 3'd1;
  assign size_ok = (size != 3'd0) && (size <= MAX_N_S);
  assign last_el = (i_q == n_m1) && (j_q == n_m1);
  assign accept  = res_valid && res_ready;
  assign prod    = {{DATA_W{1'b0}}, a_data} * {{DATA_W{1'b0}}, b_data};
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Addresses follow the counters; the counters only move in IDLE->MAC, MAC and OUT->MAC,
  // so the address ports naturally hold their last value in every other state.
  always_comb begin
    state_d = state_q;
    a_addr  = ADDR_W'(i_q) * ADDR_W'(n_q) + ADDR_W'(k_q);
    b_addr  = ADDR_W'(k_q) * ADDR_W'(n_q) + ADDR_W'(j_q);
    case (state_q)
      IDLE:    if (start && size_ok) state_d = MAC;
      MAC:     if (k_q == n_m1)      state_d = DRAIN;
      DRAIN:                         state_d = OUT;
      OUT:     if (accept)           state_d = res_last ? FIN : MAC;
      FIN:                           state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (size_ok) begin
              n_q   <= size;
              i_q   <= '0;
              j_q   <= '0;
              k_q   <= '0;
              acc_q <= '0;
            end else begin
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        MAC: begin
          // read data lags the address by one cycle, so this edge carries the product for k-1
          if (k_q != 3'd0) acc_q <= acc_q + ACC_W'(prod);
          if (k_q != n_m1) k_q <= k_q + 3'd1;
        end
        DRAIN: begin
          res_data  <= acc_q + ACC_W'(prod);
          res_valid <= 1'b1;
          res_last  <= last_el;
        end
        OUT: begin
          if (accept) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            acc_q     <= '0;
            if (!res_last) begin
              k_q <= '0;
              if (j_q == n_m1) begin
                j_q <= '0;
                i_q <= i_q + 3'd1;
              end else begin
                j_q <= j_q + 3'd1;
              end
            end
          end
        end
        FIN:     done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: behavioural A/B memories with one-cycle read latency,
// hand-computed result vectors, latency/handshake/reset checks via immediate assertions.
module tb_matmul_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  size;
  logic [3:0]  a_addr, b_addr;
  logic [7:0]  a_data, b_data;
  logic [17:0] res_data;
  logic        res_valid, res_ready, res_last, busy, done, err;

  logic [7:0]  mem_a [16];
  logic [7:0]  mem_b [16];
  int          exp_v [16];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_data <= mem_a[a_addr];
    b_data <= mem_b[b_addr];
  end

  matmul_engine #(.DATA_W(8), .MAX_N(4), .ADDR_W(4), .ACC_W(18)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size),
    .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr), .b_data(b_data),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .res_last(res_last),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a_addr"},    32'(a_addr),    0);
    check({tag, ".b_addr"},    32'(b_addr),    0);
    check({tag, ".res_data"},  32'(res_data),  0);
    check({tag, ".res_valid"}, 32'(res_valid), 0);
    check({tag, ".res_last"},  32'(res_last),  0);
    check({tag, ".busy"},      32'(busy),      0);
    check({tag, ".done"},      32'(done),      0);
    check({tag, ".err"},       32'(err),       0);
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'd0;
      mem_b[i] = 8'd0;
      exp_v[i] = 0;
    end
  endtask

  task automatic load_n2();
    clear_mems();
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(i + 5);
    end
    exp_v[0] = 19; exp_v[1] = 22; exp_v[2] = 43; exp_v[3] = 50;
  endtask

  // mode 0: res_ready always high; mode 1: res_ready high one cycle in three.
  // A stray start (size 2) is injected mid-job and must be ignored.
  task automatic run_job(input int n, input int mode, input int exp_lat, input int exp_busy);
    int          cyc, beats, last_acc, busy_cnt;
    bit          first_seen, held, done_seen, err_seen;
    logic [17:0] held_data;
    beats = 0; last_acc = -100; busy_cnt = 0;
    first_seen = 0; held = 0; done_seen = 0; err_seen = 0; held_data = '0;
    @(negedge clk);
    start = 1'b1;
    size  = 3'(n);
    @(negedge clk);
    start = 1'b0;
    size  = 3'd7;
    cyc   = 0;
    while (!done_seen && cyc < 400) begin
      start     = (cyc == 5);
      size      = (cyc == 5) ? 3'd2 : 3'd7;
      res_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
      if (busy) busy_cnt++;
      if (err) err_seen = 1;
      if (res_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          check("first_valid_latency", cyc, exp_lat);
        end
        if (held) check("stall_hold_data", 32'(res_data), 32'(held_data));
        if (res_ready) begin
          check("res_data", 32'(res_data), (beats < 16) ? exp_v[beats] : -1);
          check("res_last", 32'(res_last), (beats == n * n - 1) ? 1 : 0);
          beats++;
          last_acc = cyc;
          held = 0;
        end else begin
          held = 1;
          held_data = res_data;
        end
      end
      if (done) begin
        done_seen = 1;
        check("done_latency", cyc, last_acc + 2);
        check("busy_at_done", 32'(busy), 0);
      end
      if (!done_seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done_seen), 1);
    check("beat_count", beats, n * n);
    check("err_during_job", 32'(err_seen), 0);
    if (exp_busy >= 0) check("busy_cycles", busy_cnt, exp_busy);
    @(negedge clk);
    check("done_single_cycle", 32'(done), 0);
    check("valid_after_job", 32'(res_valid), 0);
  endtask

  task automatic bad_start(input logic [2:0] sz);
    @(negedge clk);
    start = 1'b1;
    size  = sz;
    @(negedge clk);
    start = 1'b0;
    check("bad_size.err",       32'(err),       1);
    check("bad_size.done",      32'(done),      1);
    check("bad_size.busy",      32'(busy),      0);
    check("bad_size.res_valid", 32'(res_valid), 0);
    @(negedge clk);
    check("bad_size.err_clear",  32'(err),  0);
    check("bad_size.done_clear", 32'(done), 0);
    check("bad_size.busy_after", 32'(busy), 0);
  endtask

  initial begin
    bit stray;
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stray;
    start = 1'b0; size = 3'd0; res_ready = 1'b0;
    clear_mems();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    load_n2();
    run_job(2, 0, 3, 17);

    clear_mems();
    mem_a[0] = 8'd255; mem_b[0] = 8'd255; exp_v[0] = 65025;
    run_job(1, 0, 2, 4);

    clear_mems();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'd255;
      mem_b[i] = 8'd255;
      exp_v[i] = 260100;
    end
    run_job(4, 0, 5, 97);

    clear_mems();
    for (int r = 0; r < 3; r++) mem_a[r * 3 + r] = 8'd1;
    for (int i = 0; i < 9; i++) begin
      mem_b[i] = 8'(i + 1);
      exp_v[i] = i + 1;
    end
    run_job(3, 1, 4, -1);

    bad_start(3'd0);
    bad_start(3'd5);
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid || busy) stray = 1;
    end
    check("bad_size.no_activity", 32'(stray), 0);

    // abort an N=2 job while it is multiplying element (1,0)
    load_n2();
    @(negedge clk);
    start = 1'b1; size = 3'd2;
    @(negedge clk);
    start = 1'b0; size = 3'd7; res_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("abort.a_addr_mac10", 32'(a_addr), 2);
    check("abort.b_addr_mac10", 32'(b_addr), 0);
    check("abort.busy_before",  32'(busy),   1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid || done || busy) stray = 1;
    end
    check("abort.no_activity_after", 32'(stray), 0);
    run_job(2, 0, 3, 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
